// File: rtl/data_mem_ctrl_if.sv
// Load/store request bus between the datapath (master) and the data memory controller (slave).
interface data_mem_ctrl_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output mem_rd, mem_wr, funct3, addr, wdata,
        input  rdata, busy, done, err
    );

    modport slave (
        input  mem_rd, mem_wr, funct3, addr, wdata,
        output rdata, busy, done, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory responder: word-organised RAM with byte/half/word lanes, load extension,
// multi-cycle reads signalled through busy, and rejection of illegal requests.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam int               CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      mem_r [DEPTH_WORDS];
    logic [31:0]      rd_word_r;
    logic [1:0]       lat_off_r;
    logic [2:0]       lat_f3_r;
    logic [31:0]      rdata_r;
    logic             done_r;
    logic             err_r;

    logic             both_s;
    logic             f3_ok_s;
    logic             align_ok_s;
    logic             range_ok_s;
    logic             legal_s;
    logic             accept_rd_s;
    logic             accept_wr_s;
    logic             reject_s;
    logic             busy_s;
    logic             rd_last_s;
    logic [IDX_W-1:0] idx_s;
    logic [3:0]       be_s;
    logic [31:0]      wword_s;

    function automatic logic f3_legal(input logic is_rd, input logic [2:0] f3);
        logic ok;
        if (is_rd) begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                 ok = 1'b0;
            endcase
        end else begin
            ok = (f3 < 3'd3);
        end
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data is replicated so the low byte/half lands in whichever lane is enabled
    function automatic logic [31:0] store_word(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{wd[7:0]}};
            2'b01:   w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request decode: legality of the request currently presented on the bus
    always_comb begin
        both_s     = bus.mem_rd & bus.mem_wr;
        f3_ok_s    = f3_legal(bus.mem_rd, bus.funct3);
        align_ok_s = is_aligned(bus.funct3, bus.addr[1:0]);
        range_ok_s = (bus.addr[31:2] < DEPTH_LIM);
        legal_s    = ~both_s & f3_ok_s & align_ok_s & range_ok_s;
        idx_s      = bus.addr[IDX_W+1:2];
        be_s       = lane_enables(bus.funct3, bus.addr[1:0]);
        wword_s    = store_word(bus.funct3, bus.wdata);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_rd_s) begin
                    state_nxt_s = RD_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_r == '0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; reset masks every accept and the stall
    always_comb begin
        accept_rd_s = 1'b0;
        accept_wr_s = 1'b0;
        reject_s    = 1'b0;
        busy_s      = 1'b0;
        rd_last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rst) begin
                    accept_rd_s = bus.mem_rd & ~bus.mem_wr & legal_s;
                    accept_wr_s = bus.mem_wr & ~bus.mem_rd & legal_s;
                    reject_s    = (bus.mem_rd | bus.mem_wr) & ~legal_s;
                    busy_s      = accept_rd_s;
                end else begin
                    busy_s      = 1'b0;
                end
            end
            RD_WAIT: begin
                busy_s    = ~rst;
                rd_last_s = ~rst & (cnt_r == '0);
            end
            RESP:    busy_s = 1'b0;
            default: busy_s = 1'b0;
        endcase
    end

    // Wait-state counter and latched load attributes
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            lat_off_r <= 2'b00;
            lat_f3_r  <= 3'b000;
        end else if (accept_rd_s) begin
            cnt_r     <= CNT_LOAD;
            lat_off_r <= bus.addr[1:0];
            lat_f3_r  <= bus.funct3;
        end else if ((state_r == RD_WAIT) && (cnt_r != '0)) begin
            cnt_r     <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r     <= cnt_r;
        end
    end

    // Data RAM: lane-masked writes and synchronous read on load accept
    always_ff @(posedge clk) begin
        if (accept_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
        if (accept_rd_s) begin
            rd_word_r <= mem_r[idx_s];
        end
    end

    // Response registers: completion/error pulses and extended load data
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            done_r <= accept_wr_s | rd_last_s;
            err_r  <= reject_s;
            if (rd_last_s) begin
                rdata_r <= load_extend(rd_word_r, lat_off_r, lat_f3_r);
            end
        end
    end

    assign bus.busy  = busy_s;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;
endmodule
